// File: rtl/scarv_cop_dispatch.sv
// Single-issue dispatch controller for the SCARV coprocessor: accepts one CPU
// instruction, checks its decoded class, issues it to one FU and returns a status.
//
//   state  | meaning
//   IDLE   | ready to accept an instruction from the CPU
//   DECODE | decoder settles on the registered encoding; legality check
//   EXEC   | one-hot issue strobe held until done, abort or timeout
//   RESP   | status presented to the CPU until it is consumed
module scarv_cop_dispatch #(
  parameter logic [15:0] CLASS_EN = 16'h03FF,
  parameter int          TIMEOUT  = 64
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        cpu_insn_req,
  output logic        cpu_insn_ack,
  input  logic [31:0] cpu_insn_enc,
  input  logic [31:0] cpu_rs1,
  input  logic        cpu_abort,
  output logic        cpu_rsp_valid,
  input  logic        cpu_rsp_ready,
  output logic [2:0]  cpu_rsp_status,
  output logic [31:0] id_encoded,
  input  logic [3:0]  id_class,
  input  logic        id_exception,
  output logic [31:0] fu_rs1,
  output logic [15:0] fu_ivalid,
  input  logic [15:0] fu_idone,
  input  logic [15:0] fu_error,
  output logic        fu_flush,
  output logic        busy,
  output logic [31:0] retired
);

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_ABORT   = 3'd1;
  localparam logic [2:0] ST_BAD_INS = 3'd2;
  localparam logic [2:0] ST_FU_ERR  = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] enc_q, enc_d;
  logic [31:0] rs1_q, rs1_d;
  logic [3:0]  class_q, class_d;
  logic [2:0]  status_q, status_d;
  logic [7:0]  timer_q, timer_d;
  logic [31:0] retired_q, retired_d;
  logic        flush_q, flush_d;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q   <= IDLE;
      enc_q     <= '0;
      rs1_q     <= '0;
      class_q   <= '0;
      status_q  <= ST_OK;
      timer_q   <= '0;
      retired_q <= '0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      enc_q     <= enc_d;
      rs1_q     <= rs1_d;
      class_q   <= class_d;
      status_q  <= status_d;
      timer_q   <= timer_d;
      retired_q <= retired_d;
      flush_q   <= flush_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    enc_d     = enc_q;
    rs1_d     = rs1_q;
    class_d   = class_q;
    status_d  = status_q;
    timer_d   = timer_q;
    retired_d = retired_q;
    flush_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_insn_req) begin
          enc_d   = cpu_insn_enc;
          rs1_d   = cpu_rs1;
          state_d = DECODE;
        end
      end

      DECODE: begin
        // A cancel before issue wins over the legality verdict; nothing reached an FU.
        if (cpu_abort) begin
          status_d = ST_ABORT;
          state_d  = RESP;
        end else if (id_exception || !CLASS_EN[id_class]) begin
          status_d = ST_BAD_INS;
          state_d  = RESP;
        end else begin
          class_d = id_class;
          timer_d = '0;
          state_d = EXEC;
        end
      end

      EXEC: begin
        if (fu_idone[class_q]) begin
          status_d = fu_error[class_q] ? ST_FU_ERR : ST_OK;
          state_d  = RESP;
        end else if (cpu_abort) begin
          flush_d  = 1'b1;
          status_d = ST_ABORT;
          state_d  = RESP;
        end else if (timer_q == TIMER_LAST) begin
          flush_d  = 1'b1;
          status_d = ST_TIMEOUT;
          state_d  = RESP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      RESP: begin
        if (cpu_rsp_ready) begin
          if (status_q == ST_OK) retired_d = retired_q + 32'd1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign cpu_insn_ack   = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign cpu_rsp_valid  = (state_q == RESP);
  assign cpu_rsp_status = status_q;
  assign id_encoded     = enc_q;
  assign fu_rs1         = rs1_q;
  assign fu_ivalid      = (state_q == EXEC) ? (16'h0001 << class_q) : 16'h0000;
  assign fu_flush       = flush_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_scarv_cop_dispatch.sv
// Randomized bench for scarv_cop_dispatch: a stub decoder takes the class from
// enc[3:0] and the illegal flag from enc[4]; outcomes come from a transaction-level model.
module tb_scarv_cop_dispatch;

  localparam int          TMO = 4;
  localparam logic [15:0] CEN = 16'h03FF;

  logic        g_clk, g_reset;
  logic        cpu_insn_req, cpu_insn_ack;
  logic [31:0] cpu_insn_enc, cpu_rs1;
  logic        cpu_abort;
  logic        cpu_rsp_valid, cpu_rsp_ready;
  logic [2:0]  cpu_rsp_status;
  logic [31:0] id_encoded;
  logic [3:0]  id_class;
  logic        id_exception;
  logic [31:0] fu_rs1;
  logic [15:0] fu_ivalid, fu_idone, fu_error;
  logic        fu_flush, busy;
  logic [31:0] retired;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] ret_model = '0;

  scarv_cop_dispatch #(.CLASS_EN(CEN), .TIMEOUT(TMO)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .cpu_insn_req(cpu_insn_req), .cpu_insn_ack(cpu_insn_ack),
    .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1), .cpu_abort(cpu_abort),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready),
    .cpu_rsp_status(cpu_rsp_status), .id_encoded(id_encoded),
    .id_class(id_class), .id_exception(id_exception), .fu_rs1(fu_rs1),
    .fu_ivalid(fu_ivalid), .fu_idone(fu_idone), .fu_error(fu_error),
    .fu_flush(fu_flush), .busy(busy), .retired(retired)
  );

  assign id_class     = id_encoded[3:0];
  assign id_exception = id_encoded[4];

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  // abort_ph: 0 none, 1 during DECODE, k>=2 during EXEC cycle k-1.
  // done_at: EXEC cycle (1-based) in which the FU reports done, 0 = never.
  task automatic run_txn(input logic [31:0] enc, input logic [31:0] rs1, input int done_at,
                         input logic err, input int abort_ph_in, input int rdy_dly,
                         input bit hold_req);
    logic [3:0]  cls;
    bit          legal;
    int          n;
    int          abort_ph;
    logic [2:0]  st;
    bit          fl;
    logic [15:0] ev;
    logic [31:0] nz;
    cls      = enc[3:0];
    legal    = !enc[4] && CEN[cls];
    abort_ph = abort_ph_in;
    if (abort_ph == 1 && !legal) abort_ph = 0;

    if (abort_ph == 1) begin
      n = 0; st = 3'd1; fl = 1'b0;
    end else if (!legal) begin
      n = 0; st = 3'd2; fl = 1'b0;
    end else begin
      n = TMO; st = 3'd4; fl = 1'b1;
      if (abort_ph >= 2 && abort_ph - 1 <= n) begin
        n = abort_ph - 1; st = 3'd1; fl = 1'b1;
      end
      if (done_at >= 1 && done_at <= n) begin
        n = done_at; st = err ? 3'd3 : 3'd0; fl = 1'b0;
      end
    end

    cpu_insn_req  = 1'b1;
    cpu_insn_enc  = enc;
    cpu_rs1       = rs1;
    cpu_abort     = 1'($urandom % 2);
    cpu_rsp_ready = 1'($urandom % 2);
    fu_idone      = '0;
    @(negedge g_clk);
    chk("idle_ack", 32'(cpu_insn_ack), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
    step();

    for (int c = 0; c <= n; c++) begin
      cpu_insn_req  = hold_req;
      cpu_insn_enc  = $urandom;
      cpu_rsp_ready = 1'($urandom % 2);
      cpu_abort     = (c == 0) ? (abort_ph == 1) : (abort_ph >= 2 && c == abort_ph - 1);
      nz            = $urandom;
      fu_idone      = nz[15:0];
      fu_idone[cls] = (c >= 1 && c == done_at);
      nz            = $urandom;
      fu_error      = nz[15:0];
      fu_error[cls] = err;
      ev = (c == 0) ? 16'h0000 : (16'h0001 << cls);
      @(negedge g_clk);
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_ack", 32'(cpu_insn_ack), 32'd0);
      chk("run_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
      chk("run_flush", 32'(fu_flush), 32'd0);
      chk("run_ivalid", 32'(fu_ivalid), 32'(ev));
      chk("run_id_encoded", id_encoded, enc);
      chk("run_fu_rs1", fu_rs1, rs1);
      step();
    end

    for (int r = 0; r <= rdy_dly; r++) begin
      cpu_rsp_ready = (r == rdy_dly);
      cpu_insn_req  = (r < rdy_dly) ? hold_req : 1'b0;
      cpu_abort     = 1'($urandom % 2);
      nz            = $urandom;
      fu_idone      = nz[15:0];
      @(negedge g_clk);
      chk("rsp_valid", 32'(cpu_rsp_valid), 32'd1);
      chk("rsp_status", 32'(cpu_rsp_status), 32'(st));
      chk("rsp_ack", 32'(cpu_insn_ack), 32'd0);
      chk("rsp_ivalid", 32'(fu_ivalid), 32'd0);
      chk("rsp_flush", 32'(fu_flush), 32'((r == 0) && fl));
      chk("rsp_retired", retired, ret_model);
      step();
    end
    if (st == 3'd0) ret_model = ret_model + 32'd1;

    cpu_rsp_ready = 1'b0;
    cpu_abort     = 1'b0;
    fu_idone      = '0;
    @(negedge g_clk);
    chk("post_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
    chk("post_ack", 32'(cpu_insn_ack), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_retired", retired, ret_model);
    step();
  endtask

  initial begin
    logic [31:0] e;
    int          r;
    int          ap;
    g_reset = 1'b1; cpu_insn_req = 1'b0; cpu_insn_enc = '0; cpu_rs1 = '0;
    cpu_abort = 1'b0; cpu_rsp_ready = 1'b0; fu_idone = '0; fu_error = '0;
    repeat (3) step();
    @(negedge g_clk);
    chk("rst_id_encoded", id_encoded, 32'd0);
    chk("rst_fu_rs1", fu_rs1, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
    chk("rst_ivalid", 32'(fu_ivalid), 32'd0);
    chk("rst_flush", 32'(fu_flush), 32'd0);
    chk("rst_ack", 32'(cpu_insn_ack), 32'd1);
    step();
    g_reset = 1'b0;
    step();

    run_txn(32'hABCD_0003, 32'h1111_2222, 2, 1'b0, 0, 0, 1'b0);  // OK after 2 EXEC cycles
    run_txn(32'h0000_0013, 32'h3,          1, 1'b0, 0, 0, 1'b0);  // decoder exception
    run_txn(32'h0000_000C, 32'h4,          1, 1'b0, 0, 0, 1'b0);  // disabled class 12
    run_txn(32'h5555_0005, 32'h5,          1, 1'b1, 2, 0, 1'b0);  // done+error beats abort
    run_txn(32'h0000_0007, 32'h6,          0, 1'b0, 0, 0, 1'b0);  // timeout
    run_txn(32'h0000_0009, 32'h7,          1, 1'b0, 0, 10, 1'b1); // long stall with req held
    run_txn(32'h0000_0001, 32'h8,          1, 1'b0, 1, 0, 1'b0);  // abort in DECODE
    run_txn(32'h0000_0002, 32'h9,          5, 1'b0, 4, 1, 1'b0);  // abort in EXEC cycle 3
    run_txn(32'h0000_0008, 32'hA,          4, 1'b0, 0, 0, 1'b0);  // done on last cycle beats timeout

    for (int t = 0; t < 200; t++) begin
      e = $urandom;
      if ($urandom % 8 != 0) e[4] = 1'b0;
      r  = int'($urandom % 8);
      ap = (r == 0) ? 1 : (r == 1) ? int'($urandom_range(2, 6)) : 0;
      run_txn(e, $urandom, int'($urandom_range(0, 6)), 1'($urandom % 4 == 0), ap,
              int'($urandom % 3), 1'($urandom % 2));
    end

    // Reset in the middle of EXEC.
    cpu_insn_req = 1'b1; cpu_insn_enc = 32'h0000_0003; cpu_rs1 = 32'hFFFF;
    step();
    cpu_insn_req = 1'b0; fu_idone = '0; cpu_abort = 1'b0;
    step();
    step();
    @(negedge g_clk);
    chk("pre_reset_ivalid", 32'(fu_ivalid), 32'h8);
    chk("pre_reset_retired", retired, ret_model);
    g_reset = 1'b1;
    step();
    @(negedge g_clk);
    ret_model = '0;
    chk("mid_reset_ivalid", 32'(fu_ivalid), 32'd0);
    chk("mid_reset_busy", 32'(busy), 32'd0);
    chk("mid_reset_retired", retired, 32'd0);
    chk("mid_reset_flush", 32'(fu_flush), 32'd0);
    chk("mid_reset_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
    g_reset = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge g_clk);
      chk("after_reset_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
      chk("after_reset_flush", 32'(fu_flush), 32'd0);
      step();
    end
    run_txn(32'h0000_0004, 32'h77, 1, 1'b0, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scarv_cop_dispatch.md
Name: scarv_cop_dispatch

Overview:
Single-issue instruction controller for the SCARV coprocessor. Accepts instructions from the host CPU, registers the 32-bit encoding into the combinational instruction decoder, and checks the decoded class against the enabled feature set. It then dispatches to exactly one functional unit, waits for completion, abort or timeout, and returns a status response to the CPU. It sits between the CPU coprocessor interface and the decoder and functional-unit datapaths.

Parameters:
CLASS_EN, 16'h03FF, one enable bit per 4-bit instruction class code (bit index = class); a disabled class is reported as illegal.
TIMEOUT, 64, maximum cycles spent in EXEC before a forced flush; legal range 2..255.

Ports:
g_clk  in  1  clock. One clock; reset is synchronous and active-high.
g_reset  in  1  synchronous active-high reset.
cpu_insn_req  in  1  CPU presents an instruction.
cpu_insn_ack  out  1  instruction accepted this cycle when high together with req.
cpu_insn_enc  in  32  instruction encoding.
cpu_rs1  in  32  GPR rs1 value accompanying the instruction.
cpu_abort  in  1  CPU cancels the in-flight instruction.
cpu_rsp_valid  out  1  response available.
cpu_rsp_ready  in  1  CPU consumes the response.
cpu_rsp_status  out  3  0=OK, 1=ABORT, 2=BAD_INS, 3=FU_ERR, 4=TIMEOUT.
id_encoded  out  32  registered encoding driven to the decoder and FUs.
id_class  in  4  decoder class output.
id_exception  in  1  decoder illegal-instruction flag.
fu_rs1  out  32  registered rs1 value to the FUs.
fu_ivalid  out  16  one-hot issue strobe, indexed by latched class.
fu_idone  in  16  per-class completion.
fu_error  in  16  per-class error, sampled only with the matching done bit.
fu_flush  out  1  one-cycle pulse: kill the in-flight FU operation.
busy  out  1  high in every state except IDLE.
retired  out  32  count of instructions completed with status OK.

Behaviour:
- FSM states: IDLE, DECODE, EXEC, RESP.
- Reset values: state=IDLE; id_encoded=0; fu_rs1=0; class_q=0; status=0; timer=0; retired=0; fu_flush=0; fu_ivalid=0; cpu_rsp_valid=0.
- cpu_insn_ack = (state==IDLE). busy = (state!=IDLE). cpu_rsp_valid = (state==RESP).
- IDLE: on req&&ack, latch enc→id_encoded and rs1→fu_rs1, then go to DECODE. Otherwise remain.
- DECODE (exactly 1 cycle, decoder settles on the registered encoding):
  - If id_exception, or CLASS_EN[id_class]==0, set status=BAD_INS and go to RESP. No FU sees ivalid.
  - Else latch class_q=id_class, clear timer, go to EXEC.
- EXEC:
  - fu_ivalid = one-hot(class_q), held every EXEC cycle; zero in all other states.
  - Priority per cycle: done > abort > timeout.
  - fu_idone[class_q] high: status = fu_error[class_q] ? FU_ERR : OK; go to RESP. Done bits of other classes are ignored.
  - Else cpu_abort: fu_flush=1 next cycle, status=ABORT, go to RESP.
  - Else if timer==TIMEOUT-1: fu_flush=1, status=TIMEOUT, go to RESP. Otherwise timer+1 (8-bit, never wraps within legal TIMEOUT).
- cpu_abort in DECODE: status=ABORT and go to RESP. No ivalid is ever issued; fu_flush is not pulsed. cpu_abort in IDLE or RESP is ignored.
- fu_flush is registered and asserted for exactly the first RESP cycle after an abort or timeout exit from EXEC.
- RESP: cpu_rsp_status = status. Hold until cpu_rsp_ready, then go to IDLE. retired increments (mod 2^32) on that handshake iff status==OK. A new instruction can be acked at the earliest the cycle after the response handshake.
- Minimum latency from req accepted to rsp_valid: 3 cycles when done is asserted in the first EXEC cycle; 2 cycles for BAD_INS.
- Reset mid-operation: return to IDLE next edge, outputs take reset values, no flush pulse, retired cleared.

Test Plan:
- Legal instruction, id_class=3 (enabled), fu_idone[3] on 2nd EXEC cycle → fu_ivalid=16'h0008 for 2 cycles, rsp_valid 4 cycles after ack, status=0, retired 0→1.
- id_exception=1 in DECODE → fu_ivalid never asserted, status=2, retired unchanged. Repeat with id_class=12 and CLASS_EN=16'h03FF → status=2.
- Same cycle fu_idone[5]=1, fu_error[5]=1 and cpu_abort=1 → status=3, no fu_flush, retired unchanged.
- TIMEOUT=4, FU never completes → exactly 4 EXEC cycles, fu_flush pulse 1 cycle, status=4.
- rsp_ready held low 10 cycles → rsp_valid and status stable, ack stays 0 despite req=1. Ready then rises → IDLE, ack next cycle.
- g_reset asserted in EXEC → next cycle fu_ivalid=0, busy=0, retired=0, fu_flush=0, no response issued.
